// File: rtl/mac_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | mac_pkg : shared state encoding, ReLU helper, PE group defaults |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wr_state_t;

  localparam int DATA_WIDTH    = 32;
  localparam int PE_GROUP_SIZE = 4;

  // The sign bit marks a negative value for both two's-complement and IEEE float.
  function automatic logic relu_zero(input logic relu_en, input logic sign_bit);
    return relu_en && sign_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | result_fifo : synchronous FIFO with full/empty, no fall-through |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module result_fifo #(
  parameter int DataWidth     = 32,
  parameter int FifoDepth     = 8,
  parameter int FifoAddrWidth = 3
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 push,
  input  logic [DataWidth-1:0] push_data,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [DataWidth-1:0] head
);

  localparam int PtrWidth = FifoAddrWidth + 1;

  logic [DataWidth-1:0] mem [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr;
  logic [PtrWidth-1:0]  rd_ptr;

  // Storage is cleared too, so the head reads zero after reset.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem[wr_ptr[FifoAddrWidth-1:0]] <= push_data;
        wr_ptr                         <= wr_ptr + PtrWidth'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PtrWidth'(1);
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FifoAddrWidth] != rd_ptr[FifoAddrWidth]) &&
                 (wr_ptr[FifoAddrWidth-1:0] == rd_ptr[FifoAddrWidth-1:0]);
  assign head  = mem[rd_ptr[FifoAddrWidth-1:0]];

endmodule
`default_nettype wire

// File: rtl/o_result_writer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | o_result_writer : ReLU + FIFO + sequential output-memory writer |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module o_result_writer
  import mac_pkg::*;
#(
  parameter int DataWidth      = DATA_WIDTH,
  parameter int O_PEGroupSize  = PE_GROUP_SIZE,
  parameter int O_PEAddrWidth  = 2,
  parameter int FifoDepth      = 8,
  parameter int FifoAddrWidth  = 3,
  parameter int MemAddrWidth   = 10,
  parameter int TileCountWidth = 8
) (
  input  logic                      clk,
  input  logic                      aclr,
  input  logic                      Start,
  input  logic [MemAddrWidth-1:0]   BaseAddr,
  input  logic [TileCountWidth-1:0] TileCount,
  input  logic                      ReluEn,
  input  logic                      DataInValid,
  output logic                      DataInRdy,
  input  logic [DataWidth-1:0]      DataIn,
  output logic                      Mem_WrEn,
  input  logic                      Mem_WrRdy,
  output logic [MemAddrWidth-1:0]   Mem_WrAddr,
  output logic [DataWidth-1:0]      Mem_WrData,
  output logic                      Busy,
  output logic                      Done
);

  localparam int CntWidth = TileCountWidth + O_PEAddrWidth;

  wr_state_t               state;
  wr_state_t               state_nxt;
  logic [MemAddrWidth-1:0] base_addr;
  logic [CntWidth-1:0]     total;
  logic [CntWidth-1:0]     recv_cnt;
  logic [CntWidth-1:0]     wr_cnt;
  logic                    relu_en;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    accept;
  logic                    wr_fire;
  logic                    start_job;
  logic [DataWidth-1:0]    push_data;

  assign start_job  = (state == IDLE) && Start;
  assign accept     = DataInValid && DataInRdy;
  assign wr_fire    = Mem_WrEn && Mem_WrRdy;
  assign push_data  = relu_zero(relu_en, DataIn[DataWidth-1]) ? '0 : DataIn;
  // Address arithmetic wraps modulo the memory size.
  assign Mem_WrAddr = base_addr + MemAddrWidth'(wr_cnt);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    DataInRdy = 1'b0;
    Mem_WrEn  = 1'b0;
    Busy      = 1'b1;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        Busy = 1'b0;
        if (Start) begin
          state_nxt = (TileCount == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        DataInRdy = !fifo_full && (recv_cnt < total);
        Mem_WrEn  = !fifo_empty;
        if (DataInValid && DataInRdy && ((recv_cnt + CntWidth'(1)) == total)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        Mem_WrEn = !fifo_empty;
        if (wr_cnt == total) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      base_addr <= '0;
      total     <= '0;
      relu_en   <= 1'b0;
      recv_cnt  <= '0;
      wr_cnt    <= '0;
    end else if (start_job) begin
      base_addr <= BaseAddr;
      total     <= CntWidth'(TileCount) * CntWidth'(O_PEGroupSize);
      relu_en   <= ReluEn;
      recv_cnt  <= '0;
      wr_cnt    <= '0;
    end else begin
      if (accept) begin
        recv_cnt <= recv_cnt + CntWidth'(1);
      end
      if (wr_fire) begin
        wr_cnt <= wr_cnt + CntWidth'(1);
      end
    end
  end

  result_fifo #(
    .DataWidth    (DataWidth),
    .FifoDepth    (FifoDepth),
    .FifoAddrWidth(FifoAddrWidth)
  ) u_fifo (
    .clk      (clk),
    .aclr     (aclr),
    .push     (accept),
    .push_data(push_data),
    .pop      (wr_fire),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (Mem_WrData)
  );

endmodule
`default_nettype wire

// File: tb/tb_o_result_writer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_o_result_writer : table-driven jobs with write scoreboard    |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module tb_o_result_writer;

  logic        clk = 1'b0;
  logic        aclr;
  logic        Start;
  logic [9:0]  BaseAddr;
  logic [7:0]  TileCount;
  logic        ReluEn;
  logic        DataInValid;
  logic        DataInRdy;
  logic [31:0] DataIn;
  logic        Mem_WrEn;
  logic        Mem_WrRdy;
  logic [9:0]  Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic        Busy;
  logic        Done;

  always #5 clk = ~clk;

  o_result_writer dut (
    .clk        (clk),
    .aclr       (aclr),
    .Start      (Start),
    .BaseAddr   (BaseAddr),
    .TileCount  (TileCount),
    .ReluEn     (ReluEn),
    .DataInValid(DataInValid),
    .DataInRdy  (DataInRdy),
    .DataIn     (DataIn),
    .Mem_WrEn   (Mem_WrEn),
    .Mem_WrRdy  (Mem_WrRdy),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .Busy       (Busy),
    .Done       (Done)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [9:0] base;
    logic       relu;
    int         first_vec;
  } job_t;

  exp_t       sb[$];
  int         n_tests  = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  int         wr_seen  = 0;
  int         job_idx  = 0;
  logic [9:0] exp_base = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] relu_model(input logic en, input logic [31:0] d);
    return (en && d[31]) ? 32'h0 : d;
  endfunction

  // Write monitor: every completed write is compared with the scoreboard head.
  always @(negedge clk) begin
    if (Done) done_cnt++;
    if (Mem_WrEn && Mem_WrRdy) begin
      wr_seen++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", Mem_WrAddr, Mem_WrData);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", Mem_WrAddr, e.addr);
        check("wr_data", Mem_WrData, e.data);
      end
    end
  end

  task automatic start_job(input logic [9:0] base, input logic [7:0] tiles, input logic relu);
    @(posedge clk); #1;
    Start     = 1'b1;
    BaseAddr  = base;
    TileCount = tiles;
    ReluEn    = relu;
    exp_base  = base;
    job_idx   = 0;
    @(posedge clk); #1;
    Start     = 1'b0;
    BaseAddr  = 10'h155;
    TileCount = 8'hAA;
    ReluEn    = ~relu;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [31:0] e);
    bit sent = 1'b0;
    DataInValid = 1'b1;
    DataIn      = d;
    for (int i = 0; i < 200 && !sent; i++) begin
      @(negedge clk);
      if (DataInRdy) begin
        sb.push_back('{addr: exp_base + 10'(job_idx), data: e});
        job_idx++;
        sent = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!sent) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no DataInRdy, expected accept of %0h", d);
    end
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_idle"}, Busy, 1'b0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs[8];
  job_t jobs[4];

  task automatic run_table_job(input int j);
    start_job(jobs[j].base, 8'd1, jobs[j].relu);
    check("busy_after_start", Busy, 1'b1);
    for (int k = 0; k < 4; k++) send_word(vecs[jobs[j].first_vec + k].din, vecs[jobs[j].first_vec + k].exp);
    DataInValid = 1'b0;
    wait_done("table_job");
  endtask

  initial begin
    vecs[0] = '{32'd5,        32'd5};
    vecs[1] = '{32'hFFFFFFFD, 32'hFFFFFFFD};
    vecs[2] = '{32'd7,        32'd7};
    vecs[3] = '{32'd9,        32'd9};
    vecs[4] = '{32'h80000001, 32'h0};
    vecs[5] = '{32'h00000004, 32'h4};
    vecs[6] = '{32'hBF800000, 32'h0};
    vecs[7] = '{32'h3F800000, 32'h3F800000};
    jobs[0] = '{10'h010, 1'b0, 0};
    jobs[1] = '{10'h100, 1'b1, 4};
    jobs[2] = '{10'h3FE, 1'b0, 0};
    jobs[3] = '{10'h000, 1'b1, 4};

    aclr = 1'b0; Start = 1'b0; BaseAddr = '0; TileCount = '0; ReluEn = 1'b0;
    DataInValid = 1'b0; DataIn = '0; Mem_WrRdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 aclr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy",  DataInRdy,  1'b0);
    check("rst_wren", Mem_WrEn,   1'b0);
    check("rst_addr", Mem_WrAddr, 10'h0);
    check("rst_data", Mem_WrData, 32'h0);
    check("rst_busy", Busy,       1'b0);
    check("rst_done", Done,       1'b0);

    for (int j = 0; j < 3; j++) run_table_job(j);

    // Four tiles with a 20-cycle write stall: FIFO fills at 8 and the head holds.
    Mem_WrRdy = 1'b0;
    start_job(10'h020, 8'd4, 1'b1);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          int v;
          v = (i % 2 == 1) ? -(i * 100) : (i * 100 + 1);
          send_word(32'(v), relu_model(1'b1, 32'(v)));
        end
        DataInValid = 1'b0;
      end
      begin
        repeat (5) @(negedge clk);
        check("stall_addr_early", Mem_WrAddr, 10'h020);
        check("stall_data_early", Mem_WrData, 32'd1);
        repeat (15) @(negedge clk);
        check("stall_accepts",   64'(job_idx), 64'd8);
        check("stall_rdy_low",   DataInRdy,  1'b0);
        check("stall_wren_high", Mem_WrEn,   1'b1);
        check("stall_addr_late", Mem_WrAddr, 10'h020);
        check("stall_data_late", Mem_WrData, 32'd1);
        @(posedge clk); #1;
        Mem_WrRdy = 1'b1;
      end
    join
    wait_done("stall_job");

    // Zero tiles: Done the cycle after Start, no writes.
    start_job(10'h055, 8'd0, 1'b0);
    check("zero_done", Done, 1'b1);
    check("zero_busy", Busy, 1'b1);
    @(posedge clk); #1;
    check("zero_done_end", Done, 1'b0);
    check("zero_idle", Busy, 1'b0);

    // Reset after two writes with two results still queued.
    begin
      int w0;
      int d0;
      Mem_WrRdy = 1'b0;
      start_job(10'h040, 8'd1, 1'b0);
      for (int k = 0; k < 4; k++) send_word(vecs[k].din, vecs[k].exp);
      DataInValid = 1'b0;
      w0 = wr_seen;
      Mem_WrRdy = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      Mem_WrRdy = 1'b0;
      check("abort_two_writes", 64'(wr_seen - w0), 64'd2);
      d0 = done_cnt;
      aclr = 1'b0;
      #1;
      check("abort_busy", Busy, 1'b0);
      check("abort_wren", Mem_WrEn, 1'b0);
      sb.delete();
      @(posedge clk); #1;
      aclr = 1'b1;
      Mem_WrRdy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_cnt - d0), 64'd0);
      check("abort_fifo_empty", Mem_WrEn, 1'b0);
    end

    run_table_job(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
